// File: rtl/fphub_sqrt_seq.sv
// -----------------------------------------------------------------------------
// fphub_sqrt_seq
//
// Sequential square root for HUB-format floating point numbers.
//
// Operand layout: {sign, exp[E-1:0], frac[M-1:0]}. There is an implicit
// leading 1 and an implicit ILSB of 1. There are no subnormals. The root is
// produced by a radix-2 restoring digit recurrence, one root bit per clock.
// Only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      operation request, accepted only while idle
//   x          operand, captured together with an accepted start
//   res        result, updated with finish and held until the next finish
//   finish     one-cycle completion pulse
//   computing  high while an operation is in flight
//   invalid    invalid-operation flag, updated with finish and held with res
//
// Timing, counting from the edge that accepts start:
//   special operands (zero, inf, NaN, negative) : finish one cycle later
//   normal operands                             : finish M+3 cycles later
// A start presented in the finish cycle is accepted, so back-to-back
// throughput is M+4 cycles.
// -----------------------------------------------------------------------------
module fphub_sqrt_seq #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M+E:0] x,
    output logic [M+E:0] res,
    output logic         finish,
    output logic         computing,
    output logic         invalid
);

    localparam int BIAS = 2**(E-1) - 1;
    localparam int T    = M + E;
    // Partial remainder width: the remainder never exceeds twice the partial
    // root, so M+3 magnitude bits plus a sign bit cover every trial.
    localparam int RW   = M + 4;
    // Radicand width: the significand scaled so the root is an M+1 bit integer.
    localparam int NW   = 2*M + 2;
    localparam int CW   = $clog2(M + 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UNPACK = 2'd1,
        S_ITER   = 2'd2,
        S_PACK   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Result for operands that bypass the recurrence.
    function automatic logic [T:0] f_special_res(
        input logic i_sign,
        input logic i_zero,
        input logic i_inf_pos
    );
        logic [T:0] v;
        if (i_zero) begin
            v = {i_sign, {T{1'b0}}};
        end else if (i_inf_pos) begin
            v = {1'b0, {E{1'b1}}, {M{1'b0}}};
        end else begin
            v = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        end
        return v;
    endfunction

    // Truncating the root is the whole rounding step: the implicit ILSB of the
    // HUB result already places the value halfway between the truncated
    // neighbours, which gives round-to-nearest.
    function automatic logic [T:0] f_pack_normal(
        input logic [E-1:0] i_exp,
        input logic [M-1:0] i_root_frac
    );
        return {1'b0, i_exp, i_root_frac};
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;

    logic [T:0]            r_x;
    logic [NW-1:0]         r_rad;
    logic signed [RW-1:0]  r_rem;
    logic [M:0]            r_q;
    logic [CW-1:0]         r_cnt;
    logic [E-1:0]          r_exp;
    logic [T:0]            r_res;
    logic                  r_finish;
    logic                  r_invalid;

    // -------------------------------------------------------------------------
    // Operand classification (from the captured operand)
    // -------------------------------------------------------------------------
    logic                  w_sign;
    logic [E-1:0]          w_exp;
    logic [M-1:0]          w_frac;
    logic                  w_zero;
    logic                  w_exp_max;
    logic                  w_inf;
    logic                  w_nan;
    logic                  w_special;
    logic                  w_spec_invalid;
    logic [T:0]            w_spec_res;

    assign w_sign    = r_x[T];
    assign w_exp     = r_x[T-1:M];
    assign w_frac    = r_x[M-1:0];
    assign w_zero    = (w_exp == '0);
    assign w_exp_max = (w_exp == {E{1'b1}});
    assign w_inf     = w_exp_max && (w_frac == '0);
    assign w_nan     = w_exp_max && (w_frac != '0);

    // Any negative non-zero operand, including -inf, is invalid.
    assign w_special      = w_zero || w_inf || w_nan || w_sign;
    assign w_spec_invalid = !w_zero && !(w_inf && !w_sign);
    assign w_spec_res     = f_special_res(w_sign, w_zero, w_inf && !w_sign);

    // -------------------------------------------------------------------------
    // Unpack of a normal operand
    // -------------------------------------------------------------------------
    // Unbiased exponent u = exp - BIAS. BIAS is odd, so u is odd exactly when
    // exp is even; in that case the radicand is doubled and u drops by one.
    logic                  w_u_odd;
    logic [M+1:0]          w_sig;
    logic [NW-1:0]         w_rad_init;
    logic [E-1:0]          w_exp_res;

    assign w_u_odd = ~w_exp[0];
    assign w_sig   = {1'b1, w_frac, 1'b1};

    // Scaling so that isqrt(radicand) = floor(sqrt(value) * 2^M).
    assign w_rad_init = w_u_odd ? {w_sig, {M{1'b0}}}
                                : {1'b0, w_sig, {(M-1){1'b0}}};

    // (u_adj / 2) + BIAS rewritten without a signed intermediate:
    //   exp odd : (exp + BIAS) / 2     = exp[E-1:1] + (BIAS+1)/2
    //   exp even: (exp + BIAS - 1) / 2 = exp[E-1:1] + (BIAS+1)/2 - 1
    assign w_exp_res = {1'b0, w_exp[E-1:1]}
                     + E'((BIAS + 1) / 2)
                     - E'(w_u_odd);

    // -------------------------------------------------------------------------
    // One restoring recurrence step
    // -------------------------------------------------------------------------
    logic signed [RW-1:0]  w_rem_sh;
    logic signed [RW-1:0]  w_sub;
    logic signed [RW-1:0]  w_trial;
    logic                  w_bit;
    logic signed [RW-1:0]  w_rem_next;
    logic [M:0]            w_q_next;

    // Bring down the next two radicand bits and try subtracting 4q+1.
    assign w_rem_sh   = (r_rem <<< 2)
                      | $signed({{(RW-2){1'b0}}, r_rad[NW-1:NW-2]});
    assign w_sub      = $signed({1'b0, r_q, 2'b01});
    assign w_trial    = w_rem_sh - w_sub;
    assign w_bit      = ~w_trial[RW-1];
    assign w_rem_next = w_bit ? w_trial : w_rem_sh;
    assign w_q_next   = {r_q[M-1:0], w_bit};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_UNPACK;
                end
            end
            S_UNPACK: begin
                w_state_next = w_special ? S_IDLE : S_ITER;
            end
            S_ITER: begin
                // M+1 iterations, r_cnt runs 0..M.
                if (r_cnt == CW'(M)) begin
                    w_state_next = S_PACK;
                end
            end
            S_PACK: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    logic w_computing;

    always_comb begin
        w_computing = 1'b0;
        if (r_state != S_IDLE) begin
            w_computing = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_res     <= '0;
            r_finish  <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x <= x;
                    end
                end
                S_UNPACK: begin
                    if (w_special) begin
                        r_res     <= w_spec_res;
                        r_invalid <= w_spec_invalid;
                        r_finish  <= 1'b1;
                    end else begin
                        r_rad <= w_rad_init;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_cnt <= '0;
                        r_exp <= w_exp_res;
                    end
                end
                S_ITER: begin
                    r_rad <= r_rad << 2;
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_PACK: begin
                    // Q lies in [2^M, 2^(M+1)): the result is already
                    // normalised and Q[M] is the implicit leading one.
                    r_res     <= f_pack_normal(r_exp, r_q[M-1:0]);
                    r_invalid <= 1'b0;
                    r_finish  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign res       = r_res;
    assign finish    = r_finish;
    assign invalid   = r_invalid;
    assign computing = w_computing;

endmodule

// File: tb/tb_fphub_sqrt_seq.sv
module tb_fphub_sqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Default-parameter instance (M=23, E=8)
    logic        start0;
    logic [31:0] x0;
    logic [31:0] res0;
    logic        finish0, computing0, invalid0;

    // Small instance (M=10, E=5)
    logic        start1;
    logic [15:0] x1;
    logic [15:0] res1;
    logic        finish1, computing1, invalid1;

    int n_pass  = 0;
    int n_total = 0;

    fphub_sqrt_seq #(.M(23), .E(8)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .x         (x0),
        .res       (res0),
        .finish    (finish0),
        .computing (computing0),
        .invalid   (invalid0)
    );

    fphub_sqrt_seq #(.M(10), .E(5)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .x         (x1),
        .res       (res1),
        .finish    (finish1),
        .computing (computing1),
        .invalid   (invalid1)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] res;
        logic        inv;
        int          lat;
    } vec32_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] res;
        int          lat;
    } vec16_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Starts an operation on the default instance. Called just after a rising
    // edge; returns just after the rising edge where finish was seen.
    // lat counts rising edges from the start request to the finish sample.
    task automatic op0(input logic [31:0] xv, output logic [31:0] r,
                       output logic inv, output int lat, output int comp);
        start0 = 1'b1;
        x0     = xv;
        lat    = -1;
        comp   = 0;
        r      = '0;
        inv    = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) start0 = 1'b0;
            if (finish0) begin
                lat = k;
                r   = res0;
                inv = invalid0;
                break;
            end
            if (computing0) comp++;
        end
        start0 = 1'b0;
    endtask

    task automatic op1(input logic [15:0] xv, output logic [15:0] r, output int lat);
        start1 = 1'b1;
        x1     = xv;
        lat    = -1;
        r      = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) start1 = 1'b0;
            if (finish1) begin
                lat = k;
                r   = res1;
                break;
            end
        end
        start1 = 1'b0;
    endtask

    // Reference for M=10, E=5: floor(sqrt(HUB value) * 2^M) via real sqrt
    // followed by an exact integer fix-up.
    function automatic logic [15:0] ref16(input logic [15:0] xv);
        int     e, u, ue;
        longint s, n, q;
        logic [4:0] re;
        e = int'(xv[14:10]);
        u = e - 15;
        s = 64'd2048 + longint'(xv[9:0]) * 2 + 1;
        if ((u & 1) != 0) begin
            n  = s <<< 10;
            ue = u - 1;
        end else begin
            n  = s <<< 9;
            ue = u;
        end
        q = longint'($floor($sqrt(real'(n))));
        while (q * q > n) q--;
        while ((q + 1) * (q + 1) <= n) q++;
        re = 5'(ue / 2 + 15);
        return {1'b0, re, q[9:0]};
    endfunction

    initial begin
        vec32_t      tv[9];
        vec16_t      tv16[2];
        logic [31:0] r;
        logic [15:0] r16;
        logic        inv;
        int          lat, comp;
        int          seen_fin, nf, t1, t2;
        logic [31:0] r1, r2;
        logic [15:0] xs;

        tv[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 27}; // 1.0
        tv[1] = '{32'h40800000, 32'h40000000, 1'b0, 27}; // 4.0
        tv[2] = '{32'h40000000, 32'h3FB504F3, 1'b0, 27}; // 2.0, odd exponent
        tv[3] = '{32'h41100000, 32'h40400000, 1'b0, 27}; // 9.0
        tv[4] = '{32'hC0800000, 32'h7FC00000, 1'b1, 2};  // -4.0
        tv[5] = '{32'h80000000, 32'h80000000, 1'b0, 2};  // -0
        tv[6] = '{32'h7F800000, 32'h7F800000, 1'b0, 2};  // +inf
        tv[7] = '{32'h7F800001, 32'h7FC00000, 1'b1, 2};  // NaN
        tv[8] = '{32'h3E800000, 32'h3F000000, 1'b0, 27}; // 0.25

        tv16[0] = '{16'h4400, 16'h4000, 14};
        tv16[1] = '{16'h4000, 16'h3DA8, 14};

        rst    = 1'b1;
        start0 = 1'b0;
        x0     = '0;
        start1 = 1'b0;
        x1     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset res0",       64'(res0),       64'h0);
        chk("reset finish0",    64'(finish0),    64'h0);
        chk("reset computing0", 64'(computing0), 64'h0);
        chk("reset invalid0",   64'(invalid0),   64'h0);
        chk("reset res1",       64'(res1),       64'h0);

        // Directed vectors on the default instance
        for (int i = 0; i < 9; i++) begin
            op0(tv[i].x, r, inv, lat, comp);
            chk($sformatf("vec%0d res", i),       64'(r),    64'(tv[i].res));
            chk($sformatf("vec%0d invalid", i),   64'(inv),  64'(tv[i].inv));
            chk($sformatf("vec%0d latency", i),   64'(lat),  64'(tv[i].lat));
            chk($sformatf("vec%0d computing", i), 64'(comp), 64'(tv[i].lat - 1));
            chk($sformatf("vec%0d computing low at finish", i), 64'(computing0), 64'h0);
        end

        // Reset in the middle of an operation
        start0 = 1'b1;
        x0     = 32'h40800000;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) start0 = 1'b0;
        end
        chk("mid-op computing", 64'(computing0), 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort res0",       64'(res0),       64'h0);
        chk("abort finish0",    64'(finish0),    64'h0);
        chk("abort computing0", 64'(computing0), 64'h0);
        chk("abort invalid0",   64'(invalid0),   64'h0);
        seen_fin = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (finish0) seen_fin++;
        end
        chk("no finish after abort", 64'(seen_fin), 64'h0);
        op0(32'h3F800000, r, inv, lat, comp);
        chk("after abort res",     64'(r),   64'h3F800000);
        chk("after abort latency", 64'(lat), 64'd27);

        // Start held high: back-to-back operations, mid-op starts ignored,
        // operand changes during an operation have no effect.
        start0 = 1'b1;
        x0     = 32'h40800000;
        nf = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (k == 10) x0 = 32'h7F800001;
            if (finish0) begin
                nf++;
                if (nf == 1) begin
                    t1 = k;
                    r1 = res0;
                    x0 = 32'h3F800000;
                end else begin
                    t2 = k;
                    r2 = res0;
                    start0 = 1'b0;
                    break;
                end
            end
        end
        start0 = 1'b0;
        chk("b2b first finish",  64'(t1), 64'd27);
        chk("b2b second finish", 64'(t2), 64'd54);
        chk("b2b first res",     64'(r1), 64'h40000000);
        chk("b2b second res",    64'(r2), 64'h3F800000);
        repeat (5) @(posedge clk);
        #1;
        chk("held res",        64'(res0),       64'h3F800000);
        chk("held invalid",    64'(invalid0),   64'h0);
        chk("idle finish",     64'(finish0),    64'h0);
        chk("idle computing",  64'(computing0), 64'h0);

        // Small instance: directed vectors
        for (int i = 0; i < 2; i++) begin
            op1(tv16[i].x, r16, lat);
            chk($sformatf("m10 vec%0d res", i),     64'(r16), 64'(tv16[i].res));
            chk($sformatf("m10 vec%0d latency", i), 64'(lat), 64'(tv16[i].lat));
        end
        chk("m10 invalid", 64'(invalid1), 64'h0);

        // Small instance: random normal operands against the reference
        for (int i = 0; i < 3000; i++) begin
            xs = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            op1(xs, r16, lat);
            chk($sformatf("sweep x=%04h res", xs), 64'(r16), 64'(ref16(xs)));
            if (lat != 14) begin
                chk($sformatf("sweep x=%04h latency", xs), 64'(lat), 64'd14);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
